// File: rtl/imm_encoder_pkg.sv
// Shared decode-side definitions: immediate format encoding and base opcodes.
// The immediate extender and the encoder both import this package.
package imm_encoder_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // Codes above IMM_U have no immediate layout.
  function automatic logic is_legal_src(logic [2:0] src);
    return src <= IMM_U;
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle of the immediate encoder.
// Handshake: a beat transfers on a rising clk edge where valid & ready are both 1;
// valid never waits on ready, and once raised valid and its payload hold until that transfer.
interface imm_encoder_if
  import imm_encoder_pkg::*;
#(
  parameter int WIDTH     = XLEN,
  parameter int ERR_CNT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           ImmSrc;
  logic [WIDTH-1:0]     Imm;
  logic [WIDTH-1:0]     BaseInstr;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     Instr;
  logic                 RangeErr;
  logic [ERR_CNT_W-1:0] ErrCount;

  modport master (
    output in_valid, ImmSrc, Imm, BaseInstr, out_ready,
    input  in_ready, out_valid, Instr, RangeErr, ErrCount
  );

  modport slave (
    input  in_valid, ImmSrc, Imm, BaseInstr, out_ready,
    output in_ready, out_valid, Instr, RangeErr, ErrCount
  );
endinterface

// File: rtl/imm_range_check.sv
// Flags an immediate that the selected format cannot represent exactly.
// Purely combinational; illegal format codes always flag.
module imm_range_check
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  src,
  input  logic [31:0] imm,
  output logic        range_err
);

  logic top21_same;
  logic top20_same;
  logic top12_same;

  // Sign-fit tests: every bit above the field's MSB must copy it.
  assign top21_same = (&imm[31:11]) | ~(|imm[31:11]);
  assign top20_same = (&imm[31:12]) | ~(|imm[31:12]);
  assign top12_same = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    range_err = 1'b1;
    if (is_legal_src(src)) begin
      case (src)
        IMM_I, IMM_S: range_err = ~top21_same;
        IMM_B:        range_err = ~top20_same | imm[0];
        IMM_J:        range_err = ~top12_same | imm[0];
        IMM_U:        range_err = |imm[11:0];
        default:      range_err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the I/S/B/J/U fields of a base instruction word.
// Two register stages (operands + range flag, then merged word) with valid/ready flow control.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int WIDTH     = XLEN,
  parameter int ERR_CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  imm_encoder_if.slave bus
);

  logic                 adv1;
  logic                 adv2;
  logic                 v1;
  logic                 v2;
  logic [2:0]           src1;
  logic [WIDTH-1:0]     imm1;
  logic [WIDTH-1:0]     base1;
  logic                 err1;
  logic                 range_err;
  logic [WIDTH-1:0]     merged;
  logic [WIDTH-1:0]     instr2;
  logic                 err2;
  logic [ERR_CNT_W-1:0] err_cnt;

  imm_range_check u_range (
    .src       (bus.ImmSrc),
    .imm       (bus.Imm),
    .range_err (range_err)
  );

  // A stage may load whenever it is empty or its content leaves this cycle.
  assign adv2         = ~v2 | bus.out_ready;
  assign adv1         = ~v1 | adv2;
  assign bus.in_ready = adv1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      src1  <= '0;
      imm1  <= '0;
      base1 <= '0;
      err1  <= 1'b0;
    end else if (adv1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        src1  <= bus.ImmSrc;
        imm1  <= bus.Imm;
        base1 <= bus.BaseInstr;
        err1  <= range_err;
      end
    end
  end

  // Out-of-range values are still packed by truncation; only the flag reports it.
  always_comb begin
    merged = base1;
    case (src1)
      IMM_I: merged[31:20] = imm1[11:0];
      IMM_S: begin
        merged[31:25] = imm1[11:5];
        merged[11:7]  = imm1[4:0];
      end
      IMM_B: begin
        merged[31]    = imm1[12];
        merged[30:25] = imm1[10:5];
        merged[11:8]  = imm1[4:1];
        merged[7]     = imm1[11];
      end
      IMM_J: begin
        merged[31]    = imm1[20];
        merged[30:21] = imm1[10:1];
        merged[20]    = imm1[11];
        merged[19:12] = imm1[19:12];
      end
      IMM_U: merged[31:12] = imm1[31:12];
      default: merged = base1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2     <= 1'b0;
      instr2 <= '0;
      err2   <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        instr2 <= merged;
        err2   <= err1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (v2 && bus.out_ready && err2 && !(&err_cnt)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.out_valid = v2;
  assign bus.Instr     = instr2;
  assign bus.RangeErr  = err2;
  assign bus.ErrCount  = err_cnt;

endmodule
